// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
//
// Contents:
//   mem_state_t  - responder FSM state (IDLE, BUSY, RESP)
//   WORD_BYTES   - bytes per memory word
//   STRB_W       - number of byte-lane enables per word
//   word_index() - byte address -> word index (address bits above the
//                  index are kept so callers can range-check them)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int STRB_W     = 4;

  // Full-width word index; the upper bits are deliberately not dropped so an
  // out-of-range address is detected instead of aliasing onto a real word.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with per-byte write enables.
//
// Ports:
//   clk      in   clock
//   i_en     in   access strobe; nothing happens on an edge without it
//   i_we     in   1 = write the enabled lanes, 0 = read
//   i_strb   in   byte-lane enables for writes (bit i -> bits 8i+7:8i)
//   i_addr   in   word index
//   i_wdata  in   write data
//   o_rdata  out  read data, registered on the access edge; 0 after a write
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [STRB_W-1:0] i_strb,
  input  logic [AW-1:0]     i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (i_strb[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
        r_rdata <= '0;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU memory interface: one outstanding request,
// fixed LATENCY wait cycles, then a held response.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. The requester holds req_* stable until
// accepted; the responder holds resp_* stable until resp_ready is seen.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_addr              byte address
//   req_write             1 = write, 0 = read
//   req_wdata, req_wstrb  write data and byte-lane enables
//   resp_valid/resp_ready response handshake
//   resp_rdata            read data (0 for writes and errors)
//   resp_err              misaligned or out-of-range access
//   dbg_state             current FSM state, for observation only
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output mem_state_t        dbg_state
);

  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  mem_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic              r_resp_rd;    // response carries RAM read data

  logic              w_accept;
  logic              w_perform;
  logic [31:0]       w_acc_addr;
  logic              w_acc_write;
  logic [31:0]       w_acc_wdata;
  logic [STRB_W-1:0] w_acc_wstrb;
  logic [31:0]       w_idx;
  logic              w_err;
  logic [31:0]       w_ram_rdata;

  assign w_accept = (r_state == IDLE) && req_valid;

  // With LATENCY=0 the access happens on the acceptance edge, so it must use
  // the live request; otherwise the latched copy is used.
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_acc_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;

  assign w_idx = word_index(w_acc_addr);
  assign w_err = (w_acc_addr[1:0] != 2'b00) || (w_idx >= 32'(DEPTH_WORDS));

  // rst gates the perform step so an abandoned write never reaches the RAM.
  assign w_perform = !rst &&
                     ((w_accept && (LATENCY == 0)) ||
                      ((r_state == BUSY) && (r_cnt == ONE_C)));

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_perform && !w_err),
    .i_we    (w_acc_write),
    .i_strb  (w_acc_wstrb),
    .i_addr  (w_idx[AW-1:0]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rd    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_write     <= req_write;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_cnt       <= LAT_C;
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_err;
              r_resp_rd    <= !w_err && !w_acc_write;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - ONE_C;
          if (r_cnt == ONE_C) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rd    <= !w_err && !w_acc_write;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rd    <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The RAM output register only changes on a perform edge, so it is stable
  // for the whole RESP phase; it is masked to 0 for writes and errors.
  assign resp_rdata = r_resp_rd ? w_ram_rdata : 32'h0;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign dbg_state  = r_state;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Responder end of the CPU memory interface: a word-organised data/instruction memory that accepts one request at a time over a valid/ready handshake and returns a response after a fixed, parameterised wait.
- Sits between the multi-cycle core's address/write-data/read-data path and the backing RAM.
- Lets the core's FSM run against realistic, non-zero memory latency.
- Flags misaligned and out-of-range accesses with an error instead of silently aliasing.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1.
LATENCY, 2, extra wait cycles between acceptance and response (0 allowed).

Ports:
clk  input  1  clock, all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_addr  input  32  byte address.
req_write  input  1  1 = write, 0 = read.
req_wdata  input  32  write data.
req_wstrb  input  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
resp_valid  output  1  response present.
resp_ready  input  1  requester takes the response this cycle.
resp_rdata  output  32  read data; 0 for writes and for errors.
resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset state (rst high at an edge): state IDLE, wait counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory contents are not cleared.
  - Reset mid-transaction abandons it; a write still in BUSY is not performed.
- FSM states are IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&req_ready, latch addr/write/wdata/wstrb and load the counter with LATENCY.
  - Go to BUSY if LATENCY>0, else go directly to RESP (the perform step below happens on that edge).
- BUSY:
  - req_ready=0.
  - Counter decrements each edge.
  - On the edge where the counter equals 1, perform the access and enter RESP.
- Perform step (one edge):
  - err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - If err: no RAM update, rdata=0, resp_err=1.
  - Else, read: rdata = word[addr[31:2]].
  - Else, write: update only the byte lanes enabled by wstrb, with rdata=0. wstrb=0 is a legal no-op write.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until handshake.
  - On an edge with resp_ready, go to IDLE; resp_valid, resp_rdata and resp_err return to 0 on that edge.
- Latency: the request is accepted at edge E0, so resp_valid is high in the cycle after edge E0+LATENCY.
  - Earliest handshake is that same cycle.
  - req_ready rises again in the cycle after the response handshake.
  - Throughput is one access per LATENCY+2 cycles minimum.
- req_valid during BUSY/RESP is ignored and not queued. The requester must hold the request stable until accepted.
- A read issued after a completed write to the same word returns the written data; there is no forwarding need because access is strictly serialised.
- Address bits above the word index are used only for the range check, not wrapped.

Decomposition:
- Shared package mem_pkg:
  - state enum mem_state_t {IDLE, BUSY, RESP};
  - constants WORD_BYTES=4 and STRB_W=4;
  - helper function word_index(addr).
- Sub-module mem_array:
  - single-port word RAM, DEPTH_WORDS x 32;
  - write enable plus 4-bit byte mask;
  - read data registered on the same edge as the access.
  - mem_responder owns the FSM, counter, error check and response registers.

Test Plan:
- Reset then idle, LATENCY=2 -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10, LATENCY=2 -> each response arrives in the cycle after edge E0+2; the read returns 0xDEADBEEF with resp_err=0.
- Write 0x10 wdata 0x000000AA wstrb 0x1 over the previous value, then read -> returns 0xDEADBEAA.
- Read addr 0x12, then write addr 4*DEPTH_WORDS -> both responses have resp_err=1 and rdata=0; a later read of word 0x10 is unchanged.
- LATENCY=0, read with resp_ready held low for 3 cycles -> resp_valid is high in the cycle after acceptance and stays high, with data stable for 3 cycles; req_ready stays 0 until the cycle after resp_ready=1; a second req_valid during the wait is not accepted.
- Assert rst for one edge while in BUSY on a write to 0x20 -> all outputs return to reset values, and a subsequent read of 0x20 returns the old contents.
